// File: rtl/decode_stage.sv
// RV32I decode stage with 1-cycle latency, valid/ready on both sides and a 2-entry skid buffer.
// Optional define DECODE_M_EXT_EN makes funct7=0000001 R-type (M extension) legal and drives muldiv.
module decode_stage #(
    parameter int          XLEN       = 32,
    parameter int          ALU_CTRL_W = 4,
    parameter logic [6:0]  CUSTOM_OP  = 7'b0001011
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [XLEN-1:0]       imm,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  w_en,
    output logic                  op1_sel,
    output logic                  op2_sel,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  branch,
    output logic                  jump,
    output logic                  muldiv,
    output logic                  illegal
);

    // state   | meaning
    // S_EMPTY | nothing buffered, out_valid low
    // S_ONE   | output register holds a bundle
    // S_TWO   | output and skid registers both hold bundles, input stalled
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [XLEN-1:0]       imm;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  w_en;
        logic                  op1_sel;
        logic                  op2_sel;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  branch;
        logic                  jump;
        logic                  muldiv;
        logic                  illegal;
    } bundle_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t  state;
    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    accept;
    logic    handshake;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      alu4;
    logic            wr;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    assign in_ready  = (state != S_TWO) && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        dec    = '0;
        alu4   = 4'b0000;
        wr     = 1'b0;
        dec.pc = in_pc;
        case (opcode)
            OP_R: begin
                dec.rs1 = in_inst[19:15];
                dec.rs2 = in_inst[24:20];
                dec.rd  = in_inst[11:7];
                wr      = 1'b1;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    alu4 = {in_inst[30], funct3};
                end
`ifdef DECODE_M_EXT_EN
                else if (funct7 == 7'b0000001) begin
                    dec.muldiv = 1'b1;
                    alu4       = {1'b0, funct3};
                end
`endif
                else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.rs1     = in_inst[19:15];
                dec.rd      = in_inst[11:7];
                dec.imm     = imm_i;
                dec.op2_sel = 1'b1;
                wr          = 1'b1;
                alu4        = {(funct3 == 3'b101) ? in_inst[30] : 1'b0, funct3};
                // shift-immediate encodings reuse funct7 as an opcode extension
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    dec.illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec.illegal = 1'b1;
            end
            OP_LOAD: begin
                dec.rs1     = in_inst[19:15];
                dec.rd      = in_inst[11:7];
                dec.imm     = imm_i;
                dec.op2_sel = 1'b1;
                dec.mem_rd  = 1'b1;
                wr          = 1'b1;
            end
            OP_STORE: begin
                dec.rs1     = in_inst[19:15];
                dec.rs2     = in_inst[24:20];
                dec.imm     = imm_s;
                dec.op2_sel = 1'b1;
                dec.mem_wr  = 1'b1;
            end
            OP_BRANCH: begin
                dec.rs1    = in_inst[19:15];
                dec.rs2    = in_inst[24:20];
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                alu4       = {1'b1, funct3};
            end
            OP_LUI: begin
                dec.rd      = in_inst[11:7];
                dec.imm     = imm_u;
                dec.op2_sel = 1'b1;
                wr          = 1'b1;
            end
            OP_AUIPC: begin
                dec.rd      = in_inst[11:7];
                dec.imm     = imm_u;
                dec.op1_sel = 1'b1;
                dec.op2_sel = 1'b1;
                wr          = 1'b1;
            end
            OP_JAL: begin
                dec.rd      = in_inst[11:7];
                dec.imm     = imm_j;
                dec.op1_sel = 1'b1;
                dec.op2_sel = 1'b1;
                dec.jump    = 1'b1;
                wr          = 1'b1;
            end
            OP_JALR: begin
                dec.rs1     = in_inst[19:15];
                dec.rd      = in_inst[11:7];
                dec.imm     = imm_i;
                dec.op1_sel = 1'b1;
                dec.op2_sel = 1'b1;
                dec.jump    = 1'b1;
                wr          = 1'b1;
            end
            CUSTOM_OP: begin
                dec.rs1 = in_inst[19:15];
            end
            default: dec.illegal = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11)
            dec.illegal = 1'b1;
        // an illegal bundle still flows downstream, but carries only its pc and the flag
        if (dec.illegal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end else begin
            dec.alu_ctrl = ALU_CTRL_W'(alu4);
            dec.w_en     = wr && (dec.rd != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        out_q       <= dec;
                        out_valid_q <= 1'b1;
                        state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && handshake) begin
                        out_q <= dec;
                    end else if (accept) begin
                        skid_q <= dec;
                        state  <= S_TWO;
                    end else if (handshake) begin
                        out_valid_q <= 1'b0;
                        state       <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (handshake) begin
                        out_q <= skid_q;
                        state <= S_ONE;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign imm       = out_q.imm;
    assign alu_ctrl  = out_q.alu_ctrl;
    assign w_en      = out_q.w_en;
    assign op1_sel   = out_q.op1_sel;
    assign op2_sel   = out_q.op2_sel;
    assign mem_rd    = out_q.mem_rd;
    assign mem_wr    = out_q.mem_wr;
    assign branch    = out_q.branch;
    assign jump      = out_q.jump;
    assign muldiv    = out_q.muldiv;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction checks plus randomized traffic against a queue model.
// Build with DECODE_M_EXT_EN defined to check the M-extension variant.
module tb_decode_stage;

    typedef logic [91:0] bundle_t;

`ifdef DECODE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_ctrl;
    logic        w_en, op1_sel, op2_sel, mem_rd, mem_wr, branch, jump, muldiv, illegal;

    int vectors    = 0;
    int miscompares = 0;
    bundle_t q[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_ctrl(alu_ctrl),
        .w_en(w_en), .op1_sel(op1_sel), .op2_sel(op2_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .branch(branch), .jump(jump), .muldiv(muldiv), .illegal(illegal)
    );

    function automatic bundle_t dut_bundle();
        return {out_pc, rs1, rs2, rd, imm, alu_ctrl, w_en, op1_sel, op2_sel,
                mem_rd, mem_wr, branch, jump, muldiv, illegal};
    endfunction

    // Reference decoder: field usage per instruction format, immediates by plain arithmetic.
    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] im, imm_i;
        logic [3:0]  alu;
        logic [4:0]  a, b, d;
        bit ua, ub, ud, we, o1, o2, mr, mw, br, jp, md, bad;
        int s;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        {ua, ub, ud, we, o1, o2, mr, mw, br, jp, md, bad} = '0;
        im = 0; alu = 0;
        imm_i = 32'($signed(i) >>> 20);
        case (op)
            7'h33: begin
                ua = 1; ub = 1; ud = 1; we = 1;
                if (f7 == 7'h00 || f7 == 7'h20) alu = {i[30], f3};
                else if (M_EN && f7 == 7'h01) begin md = 1; alu = {1'b0, f3}; end
                else bad = 1;
            end
            7'h13: begin
                ua = 1; ud = 1; we = 1; o2 = 1; im = imm_i;
                alu = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1;
                if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1;
            end
            7'h03: begin ua = 1; ud = 1; we = 1; o2 = 1; mr = 1; im = imm_i; end
            7'h23: begin ua = 1; ub = 1; o2 = 1; mw = 1; im = (imm_i & ~32'h1F) | 32'(i[11:7]); end
            7'h63: begin
                ua = 1; ub = 1; br = 1; alu = {1'b1, f3};
                s = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                im = 32'(s);
            end
            7'h37: begin ud = 1; we = 1; o2 = 1; im = i & 32'hFFFFF000; end
            7'h17: begin ud = 1; we = 1; o1 = 1; o2 = 1; im = i & 32'hFFFFF000; end
            7'h6F: begin
                ud = 1; we = 1; o1 = 1; o2 = 1; jp = 1;
                s = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                    + int'(i[30:21]) * 2;
                im = 32'(s);
            end
            7'h67: begin ua = 1; ud = 1; we = 1; o1 = 1; o2 = 1; jp = 1; im = imm_i; end
            7'h0B: ua = 1;
            default: bad = 1;
        endcase
        if (i[1:0] != 2'b11) bad = 1;
        if (bad) return {pc, 59'd0, 1'b1};
        a = ua ? i[19:15] : 5'd0;
        b = ub ? i[24:20] : 5'd0;
        d = ud ? i[11:7]  : 5'd0;
        return {pc, a, b, d, im, alu, we && (d != 0), o1, o2, mr, mw, br, jp, md, 1'b0};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  ops [10];
        int sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};
        w = $urandom;
        sel = $urandom_range(0, 11);
        if (sel < 10) w[6:0] = ops[sel];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // Advance one clock and move the model by the same handshake rules.
    task automatic tick();
        bit m_ready, acc, hs;
        m_ready = (q.size() < 2) && !flush && !rst;
        acc = in_valid && m_ready;
        hs = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (hs) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(in_inst, in_pc));
        end
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1; in_inst = inst; in_pc = pc; #1;
        tick();
        in_valid = 0; #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h40; out_ready = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tick(); tick();
        vectors++;
        if ({out_valid, dut_bundle()} !== 93'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", {out_valid, dut_bundle()});
        end
        rst = 0; in_valid = 0; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        out_ready = 1;
        push(32'h00500093, 32'h100);
        vectors++;
        if ({out_valid, rs1, rd, imm, op2_sel, w_en, alu_ctrl} !==
            {1'b1, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1, 4'b0000}) begin
            miscompares++; $display("FAIL addi: got %h want %h",
                {out_valid, rs1, rd, imm, op2_sel, w_en, alu_ctrl},
                {1'b1, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1, 4'b0000});
        end
        push(32'h402081B3, 32'h104);
        vectors++;
        if ({out_valid, rs1, rs2, rd, alu_ctrl, op2_sel} !==
            {1'b1, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b0}) begin
            miscompares++; $display("FAIL sub: got %h want %h",
                {out_valid, rs1, rs2, rd, alu_ctrl, op2_sel}, {1'b1, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b0});
        end
        push(32'h00512623, 32'h108);
        vectors++;
        if ({out_valid, mem_wr, imm, w_en, rs1, rs2} !== {1'b1, 1'b1, 32'd12, 1'b0, 5'd2, 5'd5}) begin
            miscompares++; $display("FAIL sw: got %h want %h",
                {out_valid, mem_wr, imm, w_en, rs1, rs2}, {1'b1, 1'b1, 32'd12, 1'b0, 5'd2, 5'd5});
        end
        push(32'hFE208EE3, 32'h10C);
        vectors++;
        if ({out_valid, branch, imm, alu_ctrl, w_en} !== {1'b1, 1'b1, 32'hFFFFFFFC, 4'b1000, 1'b0}) begin
            miscompares++; $display("FAIL beq: got %h want %h",
                {out_valid, branch, imm, alu_ctrl, w_en}, {1'b1, 1'b1, 32'hFFFFFFFC, 4'b1000, 1'b0});
        end
        vectors++;
        if (out_pc !== 32'h10C) begin
            miscompares++; $display("FAIL beq_pc: got %h want 10c", out_pc);
        end
        push(32'h022081B3, 32'h110);
        vectors++;
        if ({muldiv, illegal, w_en} !== (M_EN ? 3'b101 : 3'b010)) begin
            miscompares++; $display("FAIL mul: got %b want %b", {muldiv, illegal, w_en},
                (M_EN ? 3'b101 : 3'b010));
        end
        push(32'h00500090, 32'h114);
        vectors++;
        if ({illegal, w_en, rd} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++; $display("FAIL low_bits_illegal: got %b want 1_0_00000", {illegal, w_en, rd});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = rand_inst(); b = rand_inst();
        out_ready = 0;
        in_valid = 1; in_inst = a; in_pc = 32'h200; #1; tick();
        in_inst = b; in_pc = 32'h204; #1; tick();
        in_inst = rand_inst(); in_pc = 32'h208; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_full_ready: got %b want 0", in_ready);
        end
        tick();
        vectors++;
        if ({out_valid, dut_bundle()} !== {1'b1, ref_decode(a, 32'h200)}) begin
            miscompares++; $display("FAIL b2b_hold: got %h want %h", dut_bundle(), ref_decode(a, 32'h200));
        end
        in_valid = 0; out_ready = 1; #1;
        tick();
        vectors++;
        if ({out_valid, dut_bundle()} !== {1'b1, ref_decode(b, 32'h204)}) begin
            miscompares++; $display("FAIL b2b_second: got %h want %h", dut_bundle(), ref_decode(b, 32'h204));
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drained: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 0;
        push(rand_inst(), 32'h300);
        push(rand_inst(), 32'h304);
        flush = 1; in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h308; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        tick();
        flush = 0; in_valid = 0; #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        tick();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++; $display("FAIL flush_not_taken: got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        push(32'h402081B3, 32'h400);
        push(32'h00512623, 32'h404);
        rst = 1; #1; tick();
        rst = 0; #1;
        vectors++;
        if ({out_valid, dut_bundle()} !== 93'd0) begin
            miscompares++; $display("FAIL reset_mid_outputs: got %h want 0", {out_valid, dut_bundle()});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 300) == 0);
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFFFFFC;
            #1;
            vectors++;
            if (in_ready !== ((q.size() < 2) && !flush && !rst)) begin
                miscompares++; $display("FAIL rand_ready: cycle %0d got %b want %b", n, in_ready,
                    ((q.size() < 2) && !flush && !rst));
            end
            vectors++;
            if (out_valid !== (q.size() != 0)) begin
                miscompares++; $display("FAIL rand_valid: cycle %0d got %b want %b", n, out_valid,
                    (q.size() != 0));
            end else if (q.size() != 0) begin
                vectors++;
                if (dut_bundle() !== q[0]) begin
                    miscompares++; $display("FAIL rand_bundle: cycle %0d got %h want %h", n,
                        dut_bundle(), q[0]);
                end
            end
            tick();
        end
        rst = 0; flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
